// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and byte-lane helper for the load/store sub-word controller.
package lsu_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable mask for an access; anything that is not B/H/BU/HU is a full word.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] m;
        case (funct3)
            F3_B, F3_BU: m = 4'b0001 << off;
            F3_H, F3_HU: m = off[1] ? 4'b1100 : 4'b0011;
            F3_W:        m = 4'b1111;
            default:     m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: load extract/extend, store lane merge, misalign detect.
// Misalign reporting is enabled by the LSU_MISALIGN_ERR_EN macro.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged,
    output logic            misaligned
);

    logic            is_b_s;
    logic            is_h_s;
    logic            is_u_s;
    logic [1:0]      eff_off_s;
    logic [3:0]      lanes_s;
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] bit_mask_s;

    // Lane select, extension and merge; low offset bits are forced to natural alignment.
    always_comb begin
        is_b_s     = (funct3 == F3_B) || (funct3 == F3_BU);
        is_h_s     = (funct3 == F3_H) || (funct3 == F3_HU);
        is_u_s     = (funct3 == F3_BU) || (funct3 == F3_HU);
        eff_off_s  = is_b_s ? off : (is_h_s ? {off[1], 1'b0} : 2'b00);
        shifted_s  = rdata >> {eff_off_s, 3'b000};
        lanes_s    = lane_mask(funct3, eff_off_s);
        bit_mask_s = {XLEN{1'b0}};
        for (int i = 0; i < XLEN / 8; i++) begin
            bit_mask_s[8*i +: 8] = {8{lanes_s[i]}};
        end
        if (is_b_s) begin
            load_data = {{(XLEN-8){shifted_s[7] & ~is_u_s}}, shifted_s[7:0]};
        end else if (is_h_s) begin
            load_data = {{(XLEN-16){shifted_s[15] & ~is_u_s}}, shifted_s[15:0]};
        end else begin
            load_data = rdata;
        end
        merged = (rdata & ~bit_mask_s) | ((wdata << {eff_off_s, 3'b000}) & bit_mask_s);
`ifdef LSU_MISALIGN_ERR_EN
        misaligned = is_h_s ? off[0] : ((!is_b_s) && (off != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

endmodule

// File: rtl/lsu_subword_ctrl.sv
// RV32I load/store controller in front of a word-wide memory; sub-word stores use read-modify-write.
// Optional misaligned-access error reporting via the LSU_MISALIGN_ERR_EN macro.
module lsu_subword_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_LSB = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_rw,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state_q, state_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic [XLEN-1:0] rmw_addr_q, rmw_addr_d;
    logic [XLEN-1:0] rmw_data_q, rmw_data_d;

    logic [XLEN-1:0] word_addr_s;
    logic [XLEN-1:0] load_data_s;
    logic [XLEN-1:0] merged_s;
    logic            misaligned_s;
    logic            sub_word_s;

    assign word_addr_s = {req_addr[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
    // funct3[1]==0 covers B/H/BU/HU; every other encoding is a whole-word access.
    assign sub_word_s  = ~req_funct3[1];

    lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
        .funct3     (req_funct3),
        .off        (req_addr[1:0]),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .load_data  (load_data_s),
        .merged     (merged_s),
        .misaligned (misaligned_s)
    );

    // Next-state, response and memory-port decode; mem_rw is purely combinational.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = {XLEN{1'b0}};
        resp_err_d   = 1'b0;
        rmw_addr_d   = rmw_addr_q;
        rmw_data_d   = rmw_data_q;
        req_ready    = 1'b0;
        mem_rw       = 1'b0;
        mem_addr     = word_addr_s;
        mem_wdata    = req_wdata;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned_s) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_data_s;
                    end else if (!sub_word_s) begin
                        mem_rw       = 1'b1;
                        resp_valid_d = 1'b1;
                    end else begin
                        rmw_addr_d = word_addr_s;
                        rmw_data_d = merged_s;
                        state_d    = RMW_WR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RMW_WR: begin
                mem_rw       = 1'b1;
                mem_addr     = rmw_addr_q;
                mem_wdata    = rmw_data_q;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered response; reset abandons any pending merged write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {XLEN{1'b0}};
            resp_err_q   <= 1'b0;
            rmw_addr_q   <= {XLEN{1'b0}};
            rmw_data_q   <= {XLEN{1'b0}};
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_data_q   <= rmw_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Directed bench for lsu_subword_ctrl with a word memory model and a response scoreboard.
module tb_lsu_subword_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rw_cnt = 0;
    int resp_cnt = 0;
    int stall_cnt = 0;
    int ready_low_cnt = 0;
    logic acc_rw;

    lsu_subword_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (mem_rw) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        case (f3)
            3'b000: begin
                case (off)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            3'b001: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] f3, input logic [1:0] off);
`ifdef LSU_MISALIGN_ERR_EN
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return off[0];
            default:        return off != 2'b00;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // Event counters and response scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_rw) rw_cnt <= rw_cnt + 1;
        if (req_valid && !req_ready) stall_cnt <= stall_cnt + 1;
        if (!req_ready) ready_low_cnt <= ready_low_cnt + 1;
        if (resp_valid) begin
            resp_cnt <= resp_cnt + 1;
            if (sbq.size() == 0) begin
                chk("unexpected_resp", {31'h0, resp_valid}, 32'h0);
            end else begin
                mon_e = sbq.pop_front();
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_err", {31'h0, resp_err}, {31'h0, mon_e.err});
                chk("resp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] d);
        pre_we = 1'b1; pre_idx = 6'(idx); pre_data = d;
        ref_mem[idx] = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit model);
        int n;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) chk("accept_timeout", {31'h0, req_ready}, 32'h1);
        acc_rw = mem_rw;
        if (model) begin
            e.acc = cyc;
            e.err = 1'b0;
            e.rdata = 32'h0;
            e.lat = 1;
            if (ref_misaligned(f3, addr[1:0])) begin
                e.err = 1'b1;
            end else if (!we) begin
                e.rdata = ref_load(ref_mem[addr[7:2]], f3, addr[1:0]);
            end else begin
                ref_mem[addr[7:2]] = ref_store(ref_mem[addr[7:2]], f3, addr[1:0], wd);
                if (f3 == 3'b000 || f3 == 3'b001) e.lat = 2;
            end
            sbq.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int rw0, rl0, st0, rc0, n;
        logic exp_rw;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0; req_wdata = 32'h0; pre_we = 1'b0; pre_idx = 6'h0; pre_data = 32'h0;
        for (int i = 0; i < 64; i++) preload(i, 32'h1000_0000 + 32'(i));
        preload(16, 32'h8899AABB);
        @(negedge clk);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_mem_rw", {31'h0, mem_rw}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(1);

        // Loads with extension and lane select on word 0x40.
        issue(1'b0, 3'b000, 32'h41, 32'h0, 1'b1); idle(2);
        issue(1'b0, 3'b100, 32'h43, 32'h0, 1'b1); idle(2);
        issue(1'b0, 3'b001, 32'h42, 32'h0, 1'b1); idle(2);
        issue(1'b0, 3'b101, 32'h40, 32'h0, 1'b1); idle(2);
        issue(1'b0, 3'b011, 32'h40, 32'h0, 1'b1); idle(2);

        // Word store: single mem_rw in the accept cycle.
        rw0 = rw_cnt;
        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 1'b1);
        chk("sw_rw_at_accept", {31'h0, acc_rw}, 32'h1);
        idle(3);
        chk("sw_rw_pulses", 32'(rw_cnt - rw0), 32'h1);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1); idle(2);

        // Halfword RMW: no write at accept, one ready-low cycle, one write.
        rw0 = rw_cnt; rl0 = ready_low_cnt;
        issue(1'b1, 3'b001, 32'h22, 32'h00001234, 1'b1);
        chk("sh_rw_at_accept", {31'h0, acc_rw}, 32'h0);
        idle(3);
        chk("sh_rw_pulses", 32'(rw_cnt - rw0), 32'h1);
        chk("sh_ready_low", 32'(ready_low_cnt - rl0), 32'h1);
        chk("sh_mem_word", mem[8], 32'h1234BEEF);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1); idle(2);

        // Reset asserted while in RMW_WR abandons the write and the response.
        rw0 = rw_cnt; rc0 = resp_cnt;
        issue(1'b1, 3'b000, 32'h41, 32'h00000055, 1'b0);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rmw_mem_rw", {31'h0, mem_rw}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(3);
        chk("rst_rmw_rw_pulses", 32'(rw_cnt - rw0), 32'h0);
        chk("rst_rmw_resp", 32'(resp_cnt - rc0), 32'h0);
        chk("rst_rmw_word", mem[16], 32'h8899AABB);
        chk("rst_rmw_ready", {31'h0, req_ready}, 32'h1);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b1); idle(2);

        // Misaligned word load and halfword store.
        issue(1'b0, 3'b010, 32'h22, 32'h0, 1'b1); idle(2);
        rw0 = rw_cnt;
        exp_rw = ~ref_misaligned(3'b001, 2'b01);
        issue(1'b1, 3'b001, 32'h21, 32'h0000AAAA, 1'b1);
        idle(3);
        chk("mis_sh_rw_pulses", 32'(rw_cnt - rw0), {31'h0, exp_rw});
        chk("mis_sh_mem_word", mem[8], ref_mem[8]);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1); idle(2);

        // Back-to-back stream with req_valid held high: one stall, on SB.
        st0 = stall_cnt;
        issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b1);
        issue(1'b1, 3'b010, 32'h44, 32'h0BADF00D, 1'b1);
        issue(1'b1, 3'b000, 32'h47, 32'h0000007E, 1'b1);
        issue(1'b0, 3'b001, 32'h46, 32'h0, 1'b1);
        idle(3);
        chk("stream_stalls", 32'(stall_cnt - st0), 32'h1);
        chk("stream_mem_word", mem[17], 32'h7EADF00D);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            n++;
            @(posedge clk);
        end
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
